sort_pkt_gen: RTL and testbench

Packet stream generator for the sort datapath. It drives the sink-side streaming interface (valid/sop/eop/data with ready back-pressure) with packets of programmable length and data pattern. One instance runs in the 50 MHz sink clock domain, feeding the sort block's input port in the test harness and the board-level loopback. All outputs are registered, and every beat holds until the consumer accepts it.

---
 rtl/sort_pkt_gen_if.sv | 27 ++
 rtl/sort_pkt_gen.sv | 140 ++++++++++++++
 tb/tb_sort_pkt_gen.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sort_pkt_gen_if.sv
// Beat-level streaming bundle between the packet generator and its consumer.
// The master drives valid/sop/eop/data; the slave drives ready.
interface sort_pkt_gen_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  src_valid;
    logic                  src_sop;
    logic                  src_eop;
    logic [DATA_WIDTH-1:0] src_data;
    logic                  src_ready;

    modport master (
        output src_valid,
        output src_sop,
        output src_eop,
        output src_data,
        input  src_ready
    );

    modport slave (
        input  src_valid,
        input  src_sop,
        input  src_eop,
        input  src_data,
        output src_ready
    );
endinterface

// File: rtl/sort_pkt_gen.sv
// Packet stream generator: emits one packet per accepted start with a
// programmable length and data pattern; every output comes straight from a flop.
module sort_pkt_gen #(
    parameter int          DATA_WIDTH = 8,
    parameter int          MAX_LENGTH = 16,
    parameter logic [15:0] SEED       = 16'hACE1,
    parameter int          LEN_WIDTH  = $clog2(MAX_LENGTH + 1)
) (
    input  logic                 src_clock,
    input  logic                 src_reset,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] pkt_len,
    input  logic [1:0]           mode,
    output logic                 busy,
    output logic [15:0]          pkt_count,
    sort_pkt_gen_if.master       src
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(MAX_LENGTH);

    state_t                state_reg, state_next;
    logic [LEN_WIDTH-1:0]  len_reg, len_next;
    logic [LEN_WIDTH-1:0]  index_reg, index_next;
    logic [1:0]            mode_reg, mode_next;
    logic [15:0]           lfsr_reg, lfsr_next, lfsr_step;
    logic [15:0]           pkt_count_reg, pkt_count_next;
    logic                  sop_reg, sop_next;
    logic                  eop_reg, eop_next;
    logic [DATA_WIDTH-1:0] data_reg, data_next;
    logic                  xfer;
    logic                  last_beat;
    logic                  start_ok;

    function automatic logic [DATA_WIDTH-1:0] beat_value(
        input logic [1:0]           m,
        input logic [LEN_WIDTH-1:0] l,
        input logic [LEN_WIDTH-1:0] i,
        input logic [15:0]          s
    );
        logic [15:0] v;
        case (m)
            2'd0:    v = s;
            2'd1:    v = 16'(l) - 16'(i) - 16'd1;
            2'd2:    v = 16'(i);
            default: v = i[0] ? 16'hFFFF : 16'h0000;
        endcase
        return v[DATA_WIDTH-1:0];
    endfunction

    // Fibonacci LFSR, taps 16/14/13/11, shifting toward the MSB.
    assign lfsr_step[0] = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];
    for (genvar gi = 1; gi < 16; gi++) begin : g_lfsr_shift
        assign lfsr_step[gi] = lfsr_reg[gi-1];
    end

    assign xfer      = (state_reg == SEND) && src.src_ready;
    assign last_beat = (index_reg == len_reg - 1'b1);
    assign start_ok  = start && (pkt_len != '0);

    always_ff @(posedge src_clock) begin
        if (src_reset) begin
            state_reg     <= IDLE;
            len_reg       <= '0;
            index_reg     <= '0;
            mode_reg      <= 2'd0;
            lfsr_reg      <= SEED;
            pkt_count_reg <= 16'd0;
            sop_reg       <= 1'b0;
            eop_reg       <= 1'b0;
            data_reg      <= '0;
        end else begin
            state_reg     <= state_next;
            len_reg       <= len_next;
            index_reg     <= index_next;
            mode_reg      <= mode_next;
            lfsr_reg      <= lfsr_next;
            pkt_count_reg <= pkt_count_next;
            sop_reg       <= sop_next;
            eop_reg       <= eop_next;
            data_reg      <= data_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start_ok) state_next = SEND;
            SEND:    if (xfer && last_beat) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        len_next       = len_reg;
        mode_next      = mode_reg;
        index_next     = index_reg;
        lfsr_next      = lfsr_reg;
        pkt_count_next = pkt_count_reg;
        if (state_reg == IDLE) begin
            if (start_ok) begin
                len_next   = (pkt_len > MAX_LEN) ? MAX_LEN : pkt_len;
                mode_next  = mode;
                index_next = '0;
            end
        end else if (xfer) begin
            if (mode_reg == 2'd0) lfsr_next = lfsr_step;
            if (last_beat) begin
                index_next     = '0;
                pkt_count_next = pkt_count_reg + 16'd1;
            end else begin
                index_next = index_reg + 1'b1;
            end
        end
    end

    // Outputs are precomputed from the next state so a stalled beat re-derives itself unchanged.
    always_comb begin
        sop_next  = 1'b0;
        eop_next  = 1'b0;
        data_next = '0;
        if (state_next == SEND) begin
            sop_next  = (index_next == '0);
            eop_next  = (index_next == len_next - 1'b1);
            data_next = beat_value(mode_next, len_next, index_next, lfsr_next);
        end
    end

    assign src.src_valid = (state_reg == SEND);
    assign src.src_sop   = sop_reg;
    assign src.src_eop   = eop_reg;
    assign src.src_data  = data_reg;
    assign busy          = (state_reg == SEND);
    assign pkt_count     = pkt_count_reg;

endmodule

// File: tb/tb_sort_pkt_gen.sv
// Bench for sort_pkt_gen: scenario tasks compare captured packets against a
// queue-based model of the beat patterns, LFSR sequence and packet counter.
module tb_sort_pkt_gen;
    localparam int          DW   = 8;
    localparam int          ML   = 16;
    localparam int          LW   = 5;
    localparam logic [15:0] SEED = 16'hACE1;

    logic          src_clock = 1'b0;
    logic          src_reset;
    logic          start;
    logic [LW-1:0] pkt_len;
    logic [1:0]    mode;
    logic          busy;
    logic [15:0]   pkt_count;

    sort_pkt_gen_if #(.DATA_WIDTH(DW)) bus ();

    sort_pkt_gen #(
        .DATA_WIDTH(DW),
        .MAX_LENGTH(ML),
        .SEED(SEED),
        .LEN_WIDTH(LW)
    ) dut (
        .src_clock(src_clock),
        .src_reset(src_reset),
        .start(start),
        .pkt_len(pkt_len),
        .mode(mode),
        .busy(busy),
        .pkt_count(pkt_count),
        .src(bus)
    );

    always #5 src_clock = ~src_clock;

    int tests_run = 0;
    int fails = 0;

    logic [15:0]   model_lfsr;
    int            model_count;
    logic [DW-1:0] exp_q[$];

    logic [DW-1:0] obs_data[$];
    bit            obs_sop[$];
    bit            obs_eop[$];
    int            hold_viol, busy_viol, gap_viol, obs_cycles, obs_wait;
    bit            obs_timeout;

    task automatic model_reset();
        model_lfsr  = SEED;
        model_count = 0;
    endtask

    // Expected beat values straight from the pattern definitions.
    task automatic build_expected(input logic [1:0] m, input int req_len);
        int l;
        l = (req_len > ML) ? ML : req_len;
        exp_q.delete();
        for (int i = 0; i < l; i++) begin
            case (m)
                2'd0: begin
                    exp_q.push_back(model_lfsr[DW-1:0]);
                    model_lfsr = {model_lfsr[14:0],
                                  model_lfsr[15] ^ model_lfsr[13] ^ model_lfsr[12] ^ model_lfsr[10]};
                end
                2'd1:    exp_q.push_back(DW'(l - 1 - i));
                2'd2:    exp_q.push_back(DW'(i));
                default: exp_q.push_back((i % 2 == 1) ? {DW{1'b1}} : {DW{1'b0}});
            endcase
        end
        if (l > 0) model_count = (model_count + 1) % 65536;
    endtask

    task automatic issue_start(input int len, input logic [1:0] m);
        start   = 1'b1;
        pkt_len = LW'(len);
        mode    = m;
        @(posedge src_clock); #1;
        start   = 1'b0;
    endtask

    // Captures transferred beats until eop is accepted; ready_mode 0=always,
    // 1=random, 2=repeating 1,0,0. Returns one cycle after the eop edge.
    task automatic collect(input int ready_mode, input bit pulse_start, input int budget);
        bit            done, stalled, r, seen;
        logic          p_valid, p_sop, p_eop;
        logic [DW-1:0] p_data;
        int            n, k;
        obs_data.delete(); obs_sop.delete(); obs_eop.delete();
        hold_viol = 0; busy_viol = 0; gap_viol = 0; obs_cycles = 0; obs_wait = 0;
        obs_timeout = 0; done = 0; stalled = 0; seen = 0; n = 0; k = 0;
        p_valid = 0; p_sop = 0; p_eop = 0; p_data = '0;
        while (!done && n < budget) begin
            if (stalled && (bus.src_valid !== p_valid || bus.src_sop !== p_sop ||
                            bus.src_eop !== p_eop || bus.src_data !== p_data))
                hold_viol++;
            if (busy !== bus.src_valid) busy_viol++;
            if (bus.src_valid === 1'b1) begin
                seen = 1;
                obs_cycles++;
            end else if (!seen) begin
                obs_wait++;
            end else begin
                gap_viol++;
            end
            case (ready_mode)
                0:       r = 1'b1;
                1:       r = 1'($urandom_range(0, 1));
                default: r = (k % 3 == 0);
            endcase
            if (bus.src_valid === 1'b1) k++;
            if (pulse_start && obs_cycles == 2 && bus.src_valid === 1'b1) begin
                start   = 1'b1;
                pkt_len = LW'($urandom_range(1, 31));
                mode    = 2'($urandom_range(0, 3));
            end else begin
                start = 1'b0;
            end
            bus.src_ready = r;
            if (bus.src_valid === 1'b1 && r) begin
                obs_data.push_back(bus.src_data);
                obs_sop.push_back(bus.src_sop);
                obs_eop.push_back(bus.src_eop);
                if (bus.src_eop === 1'b1) done = 1;
            end
            stalled = (bus.src_valid === 1'b1) && !r;
            p_valid = bus.src_valid; p_sop = bus.src_sop; p_eop = bus.src_eop; p_data = bus.src_data;
            @(posedge src_clock); #1;
            n++;
        end
        start = 1'b0;
        if (!done) obs_timeout = 1;
    endtask

    task automatic test_reset();
        src_reset = 1'b1; start = 1'b1; pkt_len = 5'd4; mode = 2'd2; bus.src_ready = 1'b1;
        repeat (2) @(posedge src_clock);
        #1;
        tests_run++; if (bus.src_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", bus.src_valid); end
        tests_run++; if (bus.src_sop !== 1'b0 || bus.src_eop !== 1'b0) begin fails++; $display("FAIL reset_sop_eop got %b%b want 00", bus.src_sop, bus.src_eop); end
        tests_run++; if (bus.src_data !== 8'h00) begin fails++; $display("FAIL reset_data got %h want 00", bus.src_data); end
        tests_run++; if (busy !== 1'b0 || pkt_count !== 16'd0) begin fails++; $display("FAIL reset_busy_count got %b/%0d want 0/0", busy, pkt_count); end
        start = 1'b0; src_reset = 1'b0;
        model_reset();
        $display("[TB] test_reset done");
    endtask

    task automatic test_ascending();
        issue_start(4, 2'd2);
        build_expected(2'd2, 4);
        collect(0, 0, 40);
        tests_run++; if (obs_timeout !== 1'b0 || obs_wait != 0) begin fails++; $display("FAIL asc_latency timeout=%0d wait=%0d want 0/0", obs_timeout, obs_wait); end
        tests_run++; if (obs_data.size() != exp_q.size()) begin fails++; $display("FAIL asc_size got %0d want %0d", obs_data.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_data.size(); i++) begin
            tests_run++;
            if (obs_data[i] !== exp_q[i] || obs_sop[i] !== (i == 0) || obs_eop[i] !== (i == exp_q.size() - 1)) begin
                fails++; $display("FAIL asc_beat%0d got %h sop%b eop%b want %h", i, obs_data[i], obs_sop[i], obs_eop[i], exp_q[i]);
            end
        end
        tests_run++; if (obs_cycles != 4 || gap_viol != 0 || busy_viol != 0) begin fails++; $display("FAIL asc_cycles got %0d gaps %0d busyerr %0d want 4/0/0", obs_cycles, gap_viol, busy_viol); end
        tests_run++; if (bus.src_valid !== 1'b0 || busy !== 1'b0 || pkt_count !== 16'(model_count)) begin
            fails++; $display("FAIL asc_after valid%b busy%b count %0d want 0/0/%0d", bus.src_valid, busy, pkt_count, model_count); end
        $display("[TB] test_ascending: %0d beats", obs_data.size());
    endtask

    task automatic test_random_lfsr();
        logic [DW-1:0] e1, c3;
        int l;
        e1 = 8'hE1; c3 = 8'hC3;
        src_reset = 1'b1; @(posedge src_clock); #1; src_reset = 1'b0;
        model_reset();
        issue_start(2, 2'd0);
        build_expected(2'd0, 2);
        collect(0, 0, 40);
        tests_run++; if (obs_data.size() != 2) begin fails++; $display("FAIL lfsr_size got %0d want 2", obs_data.size()); end
        if (obs_data.size() == 2) begin
            tests_run++; if (obs_data[0] !== e1 || obs_data[1] !== c3) begin fails++; $display("FAIL lfsr_first got %h %h want e1 c3", obs_data[0], obs_data[1]); end
        end
        l = $urandom_range(3, 16);
        issue_start(l, 2'd0);
        build_expected(2'd0, l);
        collect(1, 0, 200);
        tests_run++; if (obs_data.size() != exp_q.size()) begin fails++; $display("FAIL lfsr2_size got %0d want %0d", obs_data.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_data.size(); i++) begin
            tests_run++;
            if (obs_data[i] !== exp_q[i]) begin fails++; $display("FAIL lfsr2_beat%0d got %h want %h", i, obs_data[i], exp_q[i]); end
        end
        tests_run++; if (pkt_count !== 16'(model_count)) begin fails++; $display("FAIL lfsr_count got %0d want %0d", pkt_count, model_count); end
        $display("[TB] test_random_lfsr: second packet %0d beats", l);
    endtask

    task automatic test_backpressure();
        issue_start(5, 2'd1);
        build_expected(2'd1, 5);
        collect(2, 0, 100);
        tests_run++; if (obs_data.size() != exp_q.size()) begin fails++; $display("FAIL bp_size got %0d want %0d", obs_data.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_data.size(); i++) begin
            tests_run++;
            if (obs_data[i] !== exp_q[i] || obs_sop[i] !== (i == 0) || obs_eop[i] !== (i == exp_q.size() - 1)) begin
                fails++; $display("FAIL bp_beat%0d got %h sop%b eop%b want %h", i, obs_data[i], obs_sop[i], obs_eop[i], exp_q[i]);
            end
        end
        tests_run++; if (hold_viol != 0 || obs_cycles != 13) begin fails++; $display("FAIL bp_hold violations %0d cycles %0d want 0/13", hold_viol, obs_cycles); end
        $display("[TB] test_backpressure: %0d beats over %0d cycles", obs_data.size(), obs_cycles);
    endtask

    task automatic test_boundaries();
        int vhigh;
        issue_start(1, 2'd3);
        build_expected(2'd3, 1);
        collect(1, 0, 50);
        tests_run++; if (obs_data.size() != 1 || obs_sop[0] !== 1'b1 || obs_eop[0] !== 1'b1 || obs_data[0] !== exp_q[0]) begin
            fails++; $display("FAIL len1 size %0d want single beat with sop=eop=1", obs_data.size()); end
        issue_start(0, 2'd2);
        vhigh = 0;
        for (int c = 0; c < 4; c++) begin
            if (bus.src_valid !== 1'b0 || busy !== 1'b0) vhigh++;
            @(posedge src_clock); #1;
        end
        tests_run++; if (vhigh != 0 || pkt_count !== 16'(model_count)) begin fails++; $display("FAIL len0 active cycles %0d count %0d want 0/%0d", vhigh, pkt_count, model_count); end
        issue_start(31, 2'd2);
        build_expected(2'd2, 31);
        collect(1, 0, 300);
        tests_run++; if (obs_data.size() != 16) begin fails++; $display("FAIL len31 size got %0d want 16", obs_data.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_data.size(); i++) begin
            tests_run++;
            if (obs_data[i] !== exp_q[i] || obs_eop[i] !== (i == 15)) begin fails++; $display("FAIL len31_beat%0d got %h eop%b want %h", i, obs_data[i], obs_eop[i], exp_q[i]); end
        end
        $display("[TB] test_boundaries: len31 gave %0d beats", obs_data.size());
    endtask

    task automatic test_start_during_send();
        int vhigh;
        issue_start(6, 2'd3);
        build_expected(2'd3, 6);
        collect(0, 1, 60);
        tests_run++; if (obs_data.size() != exp_q.size()) begin fails++; $display("FAIL sds_size got %0d want %0d", obs_data.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_data.size(); i++) begin
            tests_run++;
            if (obs_data[i] !== exp_q[i]) begin fails++; $display("FAIL sds_beat%0d got %h want %h", i, obs_data[i], exp_q[i]); end
        end
        vhigh = 0;
        for (int c = 0; c < 3; c++) begin
            if (bus.src_valid !== 1'b0) vhigh++;
            @(posedge src_clock); #1;
        end
        tests_run++; if (vhigh != 0 || pkt_count !== 16'(model_count)) begin fails++; $display("FAIL sds_idle valid cycles %0d count %0d want 0/%0d", vhigh, pkt_count, model_count); end
        $display("[TB] test_start_during_send: %0d beats", obs_data.size());
    endtask

    task automatic test_back_to_back();
        issue_start(3, 2'd2);
        build_expected(2'd2, 3);
        collect(0, 0, 40);
        tests_run++; if (bus.src_valid !== 1'b0) begin fails++; $display("FAIL b2b_gap valid %b want 0", bus.src_valid); end
        issue_start(4, 2'd1);
        build_expected(2'd1, 4);
        collect(0, 0, 40);
        tests_run++; if (obs_wait != 0 || obs_data.size() != 4) begin fails++; $display("FAIL b2b_second wait %0d size %0d want 0/4", obs_wait, obs_data.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_data.size(); i++) begin
            tests_run++;
            if (obs_data[i] !== exp_q[i] || obs_sop[i] !== (i == 0)) begin fails++; $display("FAIL b2b_beat%0d got %h sop%b want %h", i, obs_data[i], obs_sop[i], exp_q[i]); end
        end
        tests_run++; if (pkt_count !== 16'(model_count)) begin fails++; $display("FAIL b2b_count got %0d want %0d", pkt_count, model_count); end
        $display("[TB] test_back_to_back: count %0d", pkt_count);
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] e1;
        int eop_seen;
        e1 = 8'hE1; eop_seen = 0;
        bus.src_ready = 1'b1;
        issue_start(8, 2'd2);
        for (int c = 0; c < 2; c++) begin
            if (bus.src_eop === 1'b1) eop_seen++;
            @(posedge src_clock); #1;
        end
        tests_run++; if (bus.src_valid !== 1'b1 || bus.src_data !== 8'd2) begin fails++; $display("FAIL rmid_beat2 valid%b data %h want 1/02", bus.src_valid, bus.src_data); end
        src_reset = 1'b1;
        @(posedge src_clock); #1;
        src_reset = 1'b0;
        tests_run++; if (bus.src_valid !== 1'b0 || bus.src_eop !== 1'b0 || busy !== 1'b0 || pkt_count !== 16'd0 || eop_seen != 0) begin
            fails++; $display("FAIL rmid_after valid%b eop%b busy%b count %0d eops %0d want all 0", bus.src_valid, bus.src_eop, busy, pkt_count, eop_seen); end
        model_reset();
        issue_start(3, 2'd0);
        build_expected(2'd0, 3);
        collect(1, 0, 100);
        tests_run++; if (obs_data.size() != 3 || obs_data[0] !== e1) begin fails++; $display("FAIL rmid_restart size %0d first %h want 3/e1", obs_data.size(), obs_data.size() > 0 ? obs_data[0] : 8'h00); end
        for (int i = 0; i < exp_q.size() && i < obs_data.size(); i++) begin
            tests_run++;
            if (obs_data[i] !== exp_q[i]) begin fails++; $display("FAIL rmid_beat%0d got %h want %h", i, obs_data[i], exp_q[i]); end
        end
        $display("[TB] test_reset_mid: restart first beat %h", obs_data.size() > 0 ? obs_data[0] : 8'h00);
    endtask

    task automatic test_random_soak();
        int l, vhigh;
        logic [1:0] m;
        for (int t = 0; t < 20; t++) begin
            m = 2'($urandom_range(0, 3));
            l = $urandom_range(0, 20);
            issue_start(l, m);
            if (l == 0) begin
                vhigh = 0;
                for (int c = 0; c < 2; c++) begin
                    if (bus.src_valid !== 1'b0) vhigh++;
                    @(posedge src_clock); #1;
                end
                tests_run++; if (vhigh != 0) begin fails++; $display("FAIL soak%0d_len0 valid cycles %0d want 0", t, vhigh); end
            end else begin
                build_expected(m, l);
                collect(1, 0, 400);
                tests_run++; if (obs_data.size() != exp_q.size() || hold_viol != 0 || busy_viol != 0) begin
                    fails++; $display("FAIL soak%0d_shape size %0d hold %0d busy %0d want %0d/0/0", t, obs_data.size(), hold_viol, busy_viol, exp_q.size()); end
                for (int i = 0; i < exp_q.size() && i < obs_data.size(); i++) begin
                    tests_run++;
                    if (obs_data[i] !== exp_q[i] || obs_sop[i] !== (i == 0) || obs_eop[i] !== (i == exp_q.size() - 1)) begin
                        fails++; $display("FAIL soak%0d_beat%0d got %h sop%b eop%b want %h", t, i, obs_data[i], obs_sop[i], obs_eop[i], exp_q[i]);
                    end
                end
                tests_run++; if (pkt_count !== 16'(model_count)) begin fails++; $display("FAIL soak%0d_count got %0d want %0d", t, pkt_count, model_count); end
            end
            $display("[TB] soak packet %0d mode %0d len %0d", t, m, l);
        end
    endtask

    initial begin
        src_reset = 1'b1; start = 1'b0; pkt_len = '0; mode = 2'd0; bus.src_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge src_clock);
        #1;
        test_reset();
        test_ascending();
        test_random_lfsr();
        test_backpressure();
        test_boundaries();
        test_start_during_send();
        test_back_to_back();
        test_reset_mid();
        test_random_soak();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
